// File: rtl/cache_mem_controller.sv
// Memory-side responder for the data cache: arbitrates per-consumer refill/eviction
// requests onto NUM_CHANNELS memory channels and relays completions back.
//
//   state          | meaning
//   ---------------+-----------------------------------------------------------
//   IDLE           | channel free, scans consumers for the lowest unserved request
//   READ_WAITING   | mem_read_valid high, waiting for mem_read_ready
//   WRITE_WAITING  | mem_write_valid high, waiting for mem_write_ready
//   READ_RELAYING  | consumer_read_ready/data held until consumer drops read valid
//   WRITE_RELAYING | consumer_write_ready held until consumer drops write valid
module cache_mem_controller #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [ADDR_BITS*NUM_CONSUMERS-1:0]   consumer_write_address,
  input  logic [DATA_BITS*NUM_CONSUMERS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]              mem_read_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]              mem_read_ready,
  input  logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_read_data,
  output logic [NUM_CHANNELS-1:0]              mem_write_valid,
  output logic [ADDR_BITS*NUM_CHANNELS-1:0]    mem_write_address,
  output logic [DATA_BITS*NUM_CHANNELS-1:0]    mem_write_data,
  input  logic [NUM_CHANNELS-1:0]              mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam bit WR_EN = (WRITE_ENABLE != 0);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAITING,
    WRITE_WAITING,
    READ_RELAYING,
    WRITE_RELAYING
  } state_t;

  state_t                              state_q [NUM_CHANNELS];
  state_t                              state_d [NUM_CHANNELS];
  logic [CW-1:0]                       channel_consumer_q [NUM_CHANNELS];
  logic [CW-1:0]                       channel_consumer_d [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]            consumer_serving_q, consumer_serving_d;
  logic [NUM_CONSUMERS-1:0]            claimed;

  logic [NUM_CONSUMERS-1:0]            rd_ready_q, rd_ready_d;
  logic [DATA_BITS*NUM_CONSUMERS-1:0]  rd_data_q, rd_data_d;
  logic [NUM_CONSUMERS-1:0]            wr_ready_q, wr_ready_d;
  logic [NUM_CHANNELS-1:0]             m_rd_valid_q, m_rd_valid_d;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]   m_rd_addr_q, m_rd_addr_d;
  logic [NUM_CHANNELS-1:0]             m_wr_valid_q, m_wr_valid_d;
  logic [ADDR_BITS*NUM_CHANNELS-1:0]   m_wr_addr_q, m_wr_addr_d;
  logic [DATA_BITS*NUM_CHANNELS-1:0]   m_wr_data_q, m_wr_data_d;

  logic found;
  int   pick;
  int   owner;

  always_comb begin
    state_d            = state_q;
    channel_consumer_d = channel_consumer_q;
    consumer_serving_d = consumer_serving_q;
    rd_ready_d         = rd_ready_q;
    rd_data_d          = rd_data_q;
    wr_ready_d         = wr_ready_q;
    m_rd_valid_d       = m_rd_valid_q;
    m_rd_addr_d        = m_rd_addr_q;
    m_wr_valid_d       = m_wr_valid_q;
    m_wr_addr_d        = m_wr_addr_q;
    m_wr_data_d        = m_wr_data_q;
    // Claims made by lower channels this cycle hide the consumer from higher ones.
    claimed            = consumer_serving_q;
    found              = 1'b0;
    pick               = 0;
    owner              = 0;

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      pick  = 0;
      owner = int'(channel_consumer_q[c]);
      case (state_q[c])
        IDLE: begin
          for (int k = 0; k < NUM_CONSUMERS; k++) begin
            if (!found && !claimed[k] &&
                (consumer_read_valid[k] || (WR_EN && consumer_write_valid[k]))) begin
              found = 1'b1;
              pick  = k;
            end
          end
          if (found) begin
            claimed[pick]            = 1'b1;
            consumer_serving_d[pick] = 1'b1;
            channel_consumer_d[c]    = CW'(pick);
            // Eviction goes first; a pending refill is picked up by a later claim.
            if (WR_EN && consumer_write_valid[pick]) begin
              m_wr_valid_d[c]                          = 1'b1;
              m_wr_addr_d[c*ADDR_BITS +: ADDR_BITS]    = consumer_write_address[pick*ADDR_BITS +: ADDR_BITS];
              m_wr_data_d[c*DATA_BITS +: DATA_BITS]    = consumer_write_data[pick*DATA_BITS +: DATA_BITS];
              state_d[c]                               = WRITE_WAITING;
            end else begin
              m_rd_valid_d[c]                          = 1'b1;
              m_rd_addr_d[c*ADDR_BITS +: ADDR_BITS]    = consumer_read_address[pick*ADDR_BITS +: ADDR_BITS];
              state_d[c]                               = READ_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready[c]) begin
            m_rd_valid_d[c]                            = 1'b0;
            rd_data_d[owner*DATA_BITS +: DATA_BITS]    = mem_read_data[c*DATA_BITS +: DATA_BITS];
            rd_ready_d[owner]                          = 1'b1;
            state_d[c]                                 = READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready[c]) begin
            m_wr_valid_d[c]   = 1'b0;
            wr_ready_d[owner] = 1'b1;
            state_d[c]        = WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[owner]) begin
            rd_ready_d[owner]         = 1'b0;
            consumer_serving_d[owner] = 1'b0;
            state_d[c]                = IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[owner]) begin
            wr_ready_d[owner]         = 1'b0;
            consumer_serving_d[owner] = 1'b0;
            state_d[c]                = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c]            <= IDLE;
        channel_consumer_q[c] <= '0;
      end
      consumer_serving_q <= '0;
      rd_ready_q         <= '0;
      rd_data_q          <= '0;
      wr_ready_q         <= '0;
      m_rd_valid_q       <= '0;
      m_rd_addr_q        <= '0;
      m_wr_valid_q       <= '0;
      m_wr_addr_q        <= '0;
      m_wr_data_q        <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c]            <= state_d[c];
        channel_consumer_q[c] <= channel_consumer_d[c];
      end
      consumer_serving_q <= consumer_serving_d;
      rd_ready_q         <= rd_ready_d;
      rd_data_q          <= rd_data_d;
      wr_ready_q         <= wr_ready_d;
      m_rd_valid_q       <= m_rd_valid_d;
      m_rd_addr_q        <= m_rd_addr_d;
      m_wr_valid_q       <= m_wr_valid_d;
      m_wr_addr_q        <= m_wr_addr_d;
      m_wr_data_q        <= m_wr_data_d;
    end
  end

  assign consumer_read_ready  = rd_ready_q;
  assign consumer_read_data   = rd_data_q;
  assign mem_read_valid       = m_rd_valid_q;
  assign mem_read_address     = m_rd_addr_q;
  assign consumer_write_ready = WR_EN ? wr_ready_q   : '0;
  assign mem_write_valid      = WR_EN ? m_wr_valid_q : '0;
  assign mem_write_address    = WR_EN ? m_wr_addr_q  : '0;
  assign mem_write_data       = WR_EN ? m_wr_data_q  : '0;

endmodule

// File: tb/tb_cache_mem_controller.sv
// Directed bench for cache_mem_controller (8 consumers, 4 channels, writes enabled).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cache_mem_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  consumer_read_valid;
  logic [63:0] consumer_read_address;
  logic [7:0]  consumer_read_ready;
  logic [63:0] consumer_read_data;
  logic [7:0]  consumer_write_valid;
  logic [63:0] consumer_write_address;
  logic [63:0] consumer_write_data;
  logic [7:0]  consumer_write_ready;
  logic [3:0]  mem_read_valid;
  logic [31:0] mem_read_address;
  logic [3:0]  mem_read_ready;
  logic [31:0] mem_read_data;
  logic [3:0]  mem_write_valid;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_ready;

  int n_cmp = 0;
  int n_bad = 0;

  cache_mem_controller #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(8), .NUM_CHANNELS(4), .WRITE_ENABLE(1)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b1;
    consumer_read_valid = '0; consumer_read_address = '0;
    consumer_write_valid = '0; consumer_write_address = '0; consumer_write_data = '0;
    mem_read_ready = '0; mem_read_data = '0; mem_write_ready = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid} !== 24'h0) begin
      n_bad++; $display("FAIL reset_flags: got %h want 000000",
        {consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid});
    end
    n_cmp++;
    if ({consumer_read_data, mem_read_address, mem_write_address, mem_write_data} !== 160'h0) begin
      n_bad++; $display("FAIL reset_buses: got %h want 0",
        {consumer_read_data, mem_read_address, mem_write_address, mem_write_data});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    consumer_read_address[23:16] = 8'h3C;
    consumer_read_valid[2] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0001 || mem_read_address[7:0] !== 8'h3C) begin
      n_bad++; $display("FAIL single_read_issue: got valid %b addr %h want 0001 3c",
        mem_read_valid, mem_read_address[7:0]);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0001 || consumer_read_ready !== 8'h00) begin
      n_bad++; $display("FAIL single_read_wait: got valid %b ready %b want 0001 00000000",
        mem_read_valid, consumer_read_ready);
    end
    mem_read_data[7:0] = 8'hA5; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'b0000_0100 || consumer_read_data[23:16] !== 8'hA5 ||
        mem_read_valid !== 4'b0000) begin
      n_bad++; $display("FAIL single_read_resp: got ready %b data %h mvalid %b want 00000100 a5 0000",
        consumer_read_ready, consumer_read_data[23:16], mem_read_valid);
    end
    consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (consumer_read_ready !== 8'h00) begin
      n_bad++; $display("FAIL single_read_pulse: got ready %b want 00000000", consumer_read_ready);
    end
  endtask

  task automatic test_write;
    consumer_write_address[47:40] = 8'h10;
    consumer_write_data[47:40] = 8'h7F;
    consumer_write_valid[5] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_write_valid !== 4'b0001 || mem_write_address[7:0] !== 8'h10 ||
        mem_write_data[7:0] !== 8'h7F || mem_read_valid !== 4'b0000) begin
      n_bad++; $display("FAIL write_issue: got wv %b addr %h data %h rv %b want 0001 10 7f 0000",
        mem_write_valid, mem_write_address[7:0], mem_write_data[7:0], mem_read_valid);
    end
    mem_write_ready[0] = 1'b1;
    @(negedge clk);
    mem_write_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_write_ready !== 8'b0010_0000 || mem_write_valid !== 4'b0000) begin
      n_bad++; $display("FAIL write_resp: got ready %b wv %b want 00100000 0000",
        consumer_write_ready, mem_write_valid);
    end
    consumer_write_valid[5] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (consumer_write_ready !== 8'h00) begin
      n_bad++; $display("FAIL write_pulse: got ready %b want 00000000", consumer_write_ready);
    end
  endtask

  task automatic test_multi_claim;
    consumer_read_address[15:8]  = 8'h21;
    consumer_read_address[55:48] = 8'h66;
    consumer_read_valid[1] = 1'b1;
    consumer_read_valid[6] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0011 || mem_read_address[15:0] !== 16'h6621) begin
      n_bad++; $display("FAIL multi_claim: got valid %b addr %h want 0011 6621",
        mem_read_valid, mem_read_address[15:0]);
    end
    mem_read_data[15:8] = 8'hB6; mem_read_ready[1] = 1'b1;
    @(negedge clk);
    mem_read_ready[1] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'b0100_0000 || consumer_read_data[55:48] !== 8'hB6) begin
      n_bad++; $display("FAIL multi_claim_ch1: got ready %b data %h want 01000000 b6",
        consumer_read_ready, consumer_read_data[55:48]);
    end
    consumer_read_valid[6] = 1'b0;
    mem_read_data[7:0] = 8'hB1; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'b0000_0010 || consumer_read_data[15:8] !== 8'hB1) begin
      n_bad++; $display("FAIL multi_claim_ch0: got ready %b data %h want 00000010 b1",
        consumer_read_ready, consumer_read_data[15:8]);
    end
    consumer_read_valid[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sticky_ready;
    consumer_read_address[31:24] = 8'h33;
    consumer_read_valid[3] = 1'b1;
    @(negedge clk);
    mem_read_data[7:0] = 8'hC3; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (consumer_read_ready !== 8'b0000_1000 || consumer_read_data[31:24] !== 8'hC3 ||
          mem_read_valid !== 4'b0000) begin
        n_bad++; $display("FAIL sticky_hold[%0d]: got ready %b data %h mvalid %b want 00001000 c3 0000",
          i, consumer_read_ready, consumer_read_data[31:24], mem_read_valid);
      end
      if (i == 3) consumer_read_valid[3] = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (consumer_read_ready !== 8'h00 || mem_read_valid !== 4'b0000) begin
      n_bad++; $display("FAIL sticky_release: got ready %b mvalid %b want 00000000 0000",
        consumer_read_ready, mem_read_valid);
    end
  endtask

  task automatic test_rw_priority;
    consumer_read_address[63:56]  = 8'h70;
    consumer_write_address[63:56] = 8'h71;
    consumer_write_data[63:56]    = 8'h77;
    consumer_read_valid[7]  = 1'b1;
    consumer_write_valid[7] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_write_valid !== 4'b0001 || mem_read_valid !== 4'b0000 ||
        mem_write_address[7:0] !== 8'h71 || mem_write_data[7:0] !== 8'h77) begin
      n_bad++; $display("FAIL rw_write_first: got wv %b rv %b addr %h data %h want 0001 0000 71 77",
        mem_write_valid, mem_read_valid, mem_write_address[7:0], mem_write_data[7:0]);
    end
    mem_write_ready[0] = 1'b1;
    @(negedge clk);
    mem_write_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_write_ready !== 8'b1000_0000 || consumer_read_ready !== 8'h00) begin
      n_bad++; $display("FAIL rw_write_done: got wready %b rready %b want 10000000 00000000",
        consumer_write_ready, consumer_read_ready);
    end
    consumer_write_valid[7] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (consumer_write_ready !== 8'h00 || mem_read_valid !== 4'b0000) begin
      n_bad++; $display("FAIL rw_release: got wready %b rv %b want 00000000 0000",
        consumer_write_ready, mem_read_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0001 || mem_read_address[7:0] !== 8'h70) begin
      n_bad++; $display("FAIL rw_read_next: got rv %b addr %h want 0001 70",
        mem_read_valid, mem_read_address[7:0]);
    end
    mem_read_data[7:0] = 8'h7E; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'b1000_0000 || consumer_read_data[63:56] !== 8'h7E) begin
      n_bad++; $display("FAIL rw_read_done: got ready %b data %h want 10000000 7e",
        consumer_read_ready, consumer_read_data[63:56]);
    end
    consumer_read_valid[7] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    consumer_read_address[7:0] = 8'h05;
    consumer_read_valid[0] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0001) begin
      n_bad++; $display("FAIL mid_issue: got rv %b want 0001", mem_read_valid);
    end
    reset = 1'b1;
    consumer_read_valid[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0000 || mem_read_address !== 32'h0 ||
        consumer_read_ready !== 8'h00 || consumer_read_data !== 64'h0) begin
      n_bad++; $display("FAIL mid_reset: got rv %b addr %h rready %b rdata %h want all zero",
        mem_read_valid, mem_read_address, consumer_read_ready, consumer_read_data);
    end
    reset = 1'b0;
    mem_read_data[7:0] = 8'hEE; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'h00 || mem_read_valid !== 4'b0000 || consumer_read_data !== 64'h0) begin
      n_bad++; $display("FAIL mid_late_ready: got rready %b rv %b rdata %h want 00000000 0000 0",
        consumer_read_ready, mem_read_valid, consumer_read_data);
    end
    consumer_read_address[39:32] = 8'h44;
    consumer_read_valid[4] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0001 || mem_read_address[7:0] !== 8'h44) begin
      n_bad++; $display("FAIL mid_new_issue: got rv %b addr %h want 0001 44",
        mem_read_valid, mem_read_address[7:0]);
    end
    mem_read_data[7:0] = 8'h4D; mem_read_ready[0] = 1'b1;
    @(negedge clk);
    mem_read_ready[0] = 1'b0;
    n_cmp++;
    if (consumer_read_ready !== 8'b0001_0000 || consumer_read_data[39:32] !== 8'h4D) begin
      n_bad++; $display("FAIL mid_new_resp: got ready %b data %h want 00010000 4d",
        consumer_read_ready, consumer_read_data[39:32]);
    end
    consumer_read_valid[4] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_oversubscription;
    int         cnt [4];
    int         done_at [8];
    int         resp;
    int         ndone;
    int         cyc;
    int         last_lo;
    int         first_hi;
    logic [7:0] exp8;
    resp = 0; ndone = 0; cyc = 0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < 8; k++) begin
      done_at[k] = -1;
      consumer_read_address[k*8 +: 8] = 8'h10 + 8'(k);
    end
    consumer_read_valid = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b1111 || mem_read_address !== 32'h1312_1110) begin
      n_bad++; $display("FAIL over_first: got rv %b addr %h want 1111 13121110",
        mem_read_valid, mem_read_address);
    end
    while (ndone < 8 && cyc < 200) begin
      for (int c = 0; c < 4; c++) begin
        if (mem_read_ready[c]) begin
          mem_read_ready[c] = 1'b0;
        end else if (mem_read_valid[c]) begin
          cnt[c]++;
          if (cnt[c] == 3) begin
            cnt[c] = 0;
            mem_read_data[c*8 +: 8] = mem_read_address[c*8 +: 8] ^ 8'h5A;
            mem_read_ready[c] = 1'b1;
            resp++;
          end
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (consumer_read_ready[k]) begin
          n_cmp++;
          if (!consumer_read_valid[k]) begin
            n_bad++; $display("FAIL over_dup[%0d]: got ready 1 after valid dropped want 0", k);
          end else begin
            exp8 = (8'h10 + 8'(k)) ^ 8'h5A;
            if (consumer_read_data[k*8 +: 8] !== exp8) begin
              n_bad++; $display("FAIL over_data[%0d]: got %h want %h",
                k, consumer_read_data[k*8 +: 8], exp8);
            end
            done_at[k] = cyc;
            ndone++;
            consumer_read_valid[k] = 1'b0;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (ndone != 8) begin
      n_bad++; $display("FAIL over_timeout: got %0d completions want 8", ndone);
    end
    n_cmp++;
    if (resp != 8) begin
      n_bad++; $display("FAIL over_mem_requests: got %0d want 8", resp);
    end
    last_lo = -1; first_hi = 1000;
    for (int k = 0; k < 4; k++) if (done_at[k] > last_lo) last_lo = done_at[k];
    for (int k = 4; k < 8; k++) if (done_at[k] < first_hi) first_hi = done_at[k];
    n_cmp++;
    if (!(last_lo >= 0 && last_lo < first_hi)) begin
      n_bad++; $display("FAIL over_priority: got last low %0d first high %0d want low before high",
        last_lo, first_hi);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_read_valid !== 4'b0000 || consumer_read_ready !== 8'h00) begin
      n_bad++; $display("FAIL over_quiet: got rv %b ready %b want 0000 00000000",
        mem_read_valid, consumer_read_ready);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_multi_claim();
    test_sticky_ready();
    test_rw_priority();
    test_reset_mid();
    test_oversubscription();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
